alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl_if.sv | 47 ++++
 rtl/alu_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request/ALU/response bundle for alu_issue_ctrl. The master modport is the datapath side, the
// slave modport is the issue controller. Optional op_count exists only with ALU_OP_COUNT_EN.
interface alu_issue_ctrl_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OPC_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [OPC_W-1:0] in_opcode;
    logic [WIDTH-1:0] in_rn_data;
    logic [WIDTH-1:0] in_rm_data;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_branch_taken;
    logic             out_illegal;
`ifdef ALU_OP_COUNT_EN
    logic [31:0]      op_count;
`endif

    modport master (
`ifdef ALU_OP_COUNT_EN
        input  op_count,
`endif
        output in_valid, in_aluop, in_opcode, in_rn_data, in_rm_data,
        output alu_result, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_control,
        input  out_valid, out_result, out_zero, out_branch_taken, out_illegal
    );

    modport slave (
`ifdef ALU_OP_COUNT_EN
        output op_count,
`endif
        input  in_valid, in_aluop, in_opcode, in_rn_data, in_rm_data,
        input  alu_result, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_control,
        output out_valid, out_result, out_zero, out_branch_taken, out_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ALUOp/opcode, registers ALU operands, captures the ALU result and
// returns it over valid/ready. Define ALU_OP_COUNT_EN to add a saturating legal-op counter.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OPC_W = 11
) (
    input logic           clock,
    input logic           reset_n,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;
    typedef enum logic [1:0] {KindAlu, KindCbz, KindIllegal} kind_e;

    localparam logic [OPC_W-1:0] OpcAdd = OPC_W'(11'b10001011000);
    localparam logic [OPC_W-1:0] OpcSub = OPC_W'(11'b11001011000);
    localparam logic [OPC_W-1:0] OpcAnd = OPC_W'(11'b10001010000);
    localparam logic [OPC_W-1:0] OpcOrr = OPC_W'(11'b10101010000);

    state_e           r_state, w_state_next;
    kind_e            r_kind, w_kind;
    logic             w_in_ready, w_accept, w_capture;
    logic [3:0]       w_ctrl;
    logic [WIDTH-1:0] w_a, w_b;
    logic [WIDTH-1:0] r_alu_a, r_alu_b, r_out_result;
    logic [3:0]       r_alu_control;
    logic             r_out_zero, r_out_branch_taken, r_out_illegal;

    always_comb begin
        w_kind = KindAlu;
        w_ctrl = 4'b0010;
        w_a    = bus.in_rn_data;
        w_b    = bus.in_rm_data;
        case (bus.in_aluop)
            2'b00: w_ctrl = 4'b0010;
            2'b01: begin
                w_kind = KindCbz;
                w_a    = '0;
            end
            2'b10: begin
                case (bus.in_opcode)
                    OpcAdd:  w_ctrl = 4'b0010;
                    OpcSub:  w_ctrl = 4'b0110;
                    OpcAnd:  w_ctrl = 4'b0000;
                    OpcOrr:  w_ctrl = 4'b0001;
                    default: w_kind = KindIllegal;
                endcase
            end
            default: w_kind = KindIllegal;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_next = StIssue;
            end
            StIssue: w_state_next = StHold;
            StHold: begin
                // Accepting in the same cycle as the response handshake gives 2 cycles/op
                if (bus.out_ready) begin
                    w_in_ready   = 1'b1;
                    w_state_next = bus.in_valid ? StIssue : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_capture = (r_state == StIssue);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_kind             <= KindAlu;
            r_alu_a            <= '0;
            r_alu_b            <= '0;
            r_alu_control      <= 4'b0000;
            r_out_result       <= '0;
            r_out_zero         <= 1'b0;
            r_out_branch_taken <= 1'b0;
            r_out_illegal      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_kind <= w_kind;
                // Illegal requests leave the ALU inputs untouched
                if (w_kind != KindIllegal) begin
                    r_alu_a       <= w_a;
                    r_alu_b       <= w_b;
                    r_alu_control <= w_ctrl;
                end
            end
            if (w_capture) begin
                if (r_kind == KindIllegal) begin
                    r_out_result       <= '0;
                    r_out_zero         <= 1'b0;
                    r_out_branch_taken <= 1'b0;
                    r_out_illegal      <= 1'b1;
                end else begin
                    r_out_result       <= bus.alu_result;
                    r_out_zero         <= bus.alu_zero;
                    r_out_branch_taken <= (r_kind == KindCbz) & bus.alu_zero;
                    r_out_illegal      <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_OP_COUNT_EN
    logic [31:0] r_op_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op_count <= '0;
        end else if ((r_state == StHold) && bus.out_ready && !r_out_illegal
                     && (r_op_count != 32'hFFFF_FFFF)) begin
            r_op_count <= r_op_count + 32'd1;
        end
    end

    assign bus.op_count = r_op_count;
`endif

    assign bus.in_ready         = w_in_ready;
    assign bus.out_valid        = (r_state == StHold);
    assign bus.alu_a            = r_alu_a;
    assign bus.alu_b            = r_alu_b;
    assign bus.alu_control      = r_alu_control;
    assign bus.out_result       = r_out_result;
    assign bus.out_zero         = r_out_zero;
    assign bus.out_branch_taken = r_out_branch_taken;
    assign bus.out_illegal      = r_out_illegal;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: bench-side ALU, transaction-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_issue_ctrl;
    localparam logic [10:0] OpcAdd = 11'b10001011000;
    localparam logic [10:0] OpcSub = 11'b11001011000;
    localparam logic [10:0] OpcAnd = 11'b10001010000;
    localparam logic [10:0] OpcOrr = 11'b10101010000;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        br;
        logic        ill;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
    } resp_t;

    logic        clock;
    logic        reset_n;
    logic        alu_override;
    logic [63:0] tb_alu_r;
    int          n_cmp = 0;
    int          n_bad = 0;

    alu_issue_ctrl_if #(.WIDTH(64), .OPC_W(11)) bus ();

    alu_issue_ctrl #(.WIDTH(64), .OPC_W(11)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in combinational ALU; the override makes late sampling visible
    always_comb begin
        tb_alu_r = '0;
        case (bus.alu_control)
            4'b0010: tb_alu_r = bus.alu_a + bus.alu_b;
            4'b0110: tb_alu_r = bus.alu_a - bus.alu_b;
            4'b0000: tb_alu_r = bus.alu_a & bus.alu_b;
            4'b0001: tb_alu_r = bus.alu_a | bus.alu_b;
            default: tb_alu_r = '0;
        endcase
        if (alu_override) tb_alu_r = 64'hDEAD_BEEF_0000_0001;
        bus.alu_result = tb_alu_r;
        bus.alu_zero   = (tb_alu_r == 64'd0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic resp_t predict(input logic [1:0] op, input logic [10:0] opc,
                                      input logic [63:0] rn, input logic [63:0] rm);
        resp_t p;
        p.ill = 1'b0;
        p.a   = rn;
        p.b   = rm;
        p.ctrl = 4'b0010;
        p.res = '0;
        if (op == 2'b00) p.res = rn + rm;
        else if (op == 2'b01) begin
            p.a   = '0;
            p.res = rm;
        end else if (op == 2'b10 && opc == OpcAdd) p.res = rn + rm;
        else if (op == 2'b10 && opc == OpcSub) begin
            p.ctrl = 4'b0110;
            p.res  = rn - rm;
        end else if (op == 2'b10 && opc == OpcAnd) begin
            p.ctrl = 4'b0000;
            p.res  = rn & rm;
        end else if (op == 2'b10 && opc == OpcOrr) begin
            p.ctrl = 4'b0001;
            p.res  = rn | rm;
        end else p.ill = 1'b1;
        p.zero = !p.ill && (p.res == 64'd0);
        p.br   = (op == 2'b01) && p.zero;
        return p;
    endfunction

    // Reference model: outstanding transaction, its age in edges, and the ALU input registers
    bit          m_busy;
    int          m_age;
    resp_t       m_rsp;
    logic [63:0] m_a, m_b;
    logic [3:0]  m_ctrl;
    logic [31:0] m_cnt;

    always @(negedge clock) begin
        bit    exp_valid, exp_ready;
        resp_t p;
        if (!reset_n) begin
            check("rst_alu_a", bus.alu_a, 64'd0);
            check("rst_alu_b", bus.alu_b, 64'd0);
            check("rst_alu_control", 64'(bus.alu_control), 64'd0);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_result", bus.out_result, 64'd0);
            check("rst_out_flags", {61'd0, bus.out_zero, bus.out_branch_taken, bus.out_illegal},
                  64'd0);
`ifdef ALU_OP_COUNT_EN
            check("rst_op_count", 64'(bus.op_count), 64'd0);
`endif
            m_busy = 0; m_age = 0; m_a = '0; m_b = '0; m_ctrl = '0; m_cnt = '0;
        end else begin
            exp_valid = m_busy && (m_age >= 1);
            exp_ready = !m_busy || (exp_valid && bus.out_ready);
            check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
            check("alu_a", bus.alu_a, m_a);
            check("alu_b", bus.alu_b, m_b);
            check("alu_control", 64'(bus.alu_control), 64'(m_ctrl));
            if (exp_valid) begin
                check("out_result", bus.out_result, m_rsp.res);
                check("out_zero", 64'(bus.out_zero), 64'(m_rsp.zero));
                check("out_branch_taken", 64'(bus.out_branch_taken), 64'(m_rsp.br));
                check("out_illegal", 64'(bus.out_illegal), 64'(m_rsp.ill));
            end
`ifdef ALU_OP_COUNT_EN
            check("op_count", 64'(bus.op_count), 64'(m_cnt));
`endif
            if (exp_valid && bus.out_ready) begin
                if (!m_rsp.ill && m_cnt != 32'hFFFF_FFFF) m_cnt++;
                m_busy = 0;
            end else if (m_busy) m_age++;
            if (bus.in_valid && exp_ready) begin
                p = predict(bus.in_aluop, bus.in_opcode, bus.in_rn_data, bus.in_rm_data);
                m_rsp  = p;
                m_busy = 1;
                m_age  = 0;
                if (!p.ill) begin
                    m_a = p.a; m_b = p.b; m_ctrl = p.ctrl;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [10:0] opc,
                         input logic [63:0] rn, input logic [63:0] rm);
        bit ok = 0;
        bus.in_aluop   = op;
        bus.in_opcode  = opc;
        bus.in_rn_data = rn;
        bus.in_rm_data = rm;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("issue_timeout", 64'd0, 64'd1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            lat++;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic take();
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input logic [1:0] op, input logic [10:0] opc, input logic [63:0] rn,
                       input logic [63:0] rm, input logic [63:0] e_res, input logic e_zero,
                       input logic e_br, input logic e_ill, input logic [3:0] e_ctrl);
        int lat;
        issue(op, opc, rn, rm);
        wait_valid(lat);
        check("lit_latency", 64'(lat), 64'd2);
        check("lit_result", bus.out_result, e_res);
        check("lit_flags", {61'd0, bus.out_zero, bus.out_branch_taken, bus.out_illegal},
              {61'd0, e_zero, e_br, e_ill});
        check("lit_control", 64'(bus.alu_control), 64'(e_ctrl));
        take();
    endtask

    initial begin
        int lat;
        bus.in_valid = 1'b0; bus.in_aluop = '0; bus.in_opcode = '0;
        bus.in_rn_data = '0; bus.in_rm_data = '0; bus.out_ready = 1'b0;
        alu_override = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        run(2'b10, OpcAdd, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1'b0, 4'b0010);
        run(2'b10, OpcSub, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0, 1'b0, 4'b0110);
        run(2'b01, 11'd0, 64'd77, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 4'b0010);
        check("lit_cbz_a", bus.alu_a, 64'd0);
        run(2'b01, 11'd0, 64'd77, 64'd3, 64'd3, 1'b0, 1'b0, 1'b0, 4'b0010);
        run(2'b10, OpcOrr, 64'hA0, 64'h0A, 64'hAA, 1'b0, 1'b0, 1'b0, 4'b0001);

        // Back-pressure with a corrupted ALU output, then back-to-back accept
        issue(2'b00, 11'd0, 64'd100, 64'd23);
        wait_valid(lat);
        check("bp_first", bus.out_result, 64'd123);
        @(posedge clock); #1;
        alu_override = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("bp_result", bus.out_result, 64'd123);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clock); #1;
        alu_override = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_aluop = 2'b10; bus.in_opcode = OpcAnd;
        bus.in_rn_data = 64'hF0; bus.in_rm_data = 64'h3C;
        bus.in_valid = 1'b1;
        @(negedge clock);
        check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("b2b_latency", 64'(lat), 64'd2);
        check("b2b_result", bus.out_result, 64'h30);
        check("b2b_control", 64'(bus.alu_control), 64'd0);
        take();

        run(2'b10, OpcSub, 64'd20, 64'd5, 64'd15, 1'b0, 1'b0, 1'b0, 4'b0110);
        run(2'b10, 11'b11111111111, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b1, 4'b0110);
        check("ill_alu_a", bus.alu_a, 64'd20);
        run(2'b11, OpcAdd, 64'd4, 64'd4, 64'd0, 1'b0, 1'b0, 1'b1, 4'b0110);
`ifdef ALU_OP_COUNT_EN
        @(negedge clock);
        check("lit_op_count", 64'(bus.op_count), 64'd8);
`endif

        // Reset while in ISSUE
        issue(2'b10, OpcAdd, 64'd1, 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_alu_a", bus.alu_a, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("post_rst_valid", 64'(bus.out_valid), 64'd0);
            check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
